// File: rtl/reg_file_if.sv
// Register-file access bundle: decode-side read ports plus write-back port.
// The master drives indices/write data; the register file (slave) returns read data.
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] pr1;
    logic [ADDR_WIDTH-1:0] pr2;
    logic [ADDR_WIDTH-1:0] wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    modport master (
        output write, pr1, pr2, wr, wd,
        input  rd1, rd2
    );

    modport slave (
        input  write, pr1, pr2, wr, wd,
        output rd1, rd2
    );
endinterface : reg_file_if

// File: rtl/reg_file.sv
// 2-read/1-write register file with hard-wired zero register and
// write-through bypass so a value written this cycle is readable this cycle.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_en;

    // Index 0 never accepts a write, so its flop simply holds its reset value.
    assign wr_en = rf.write && (rf.wr != '0);

    always_comb begin
        // NOTE: copy the whole current state first so every element of regs_d
        // is assigned on every path; otherwise the tool infers latches.
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rf.wr] = rf.wd;
        end
    end

    // NOTE: the storage array sits in the async-reset block on purpose:
    // architectural state must read as zero immediately after reset, so this
    // memory is built from resettable flops rather than an unreset RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep all state changes simultaneous
            // at the edge, independent of statement order.
            regs_q <= regs_d;
        end
    end

    // Bypass is gated by reset so both ports read zero while reset is low.
    always_comb begin
        rf.rd1 = '0;
        if (rf.pr1 != '0) begin
            if (reset && wr_en && (rf.wr == rf.pr1)) begin
                rf.rd1 = rf.wd;
            end else begin
                rf.rd1 = regs_q[rf.pr1];
            end
        end
    end

    always_comb begin
        rf.rd2 = '0;
        if (rf.pr2 != '0) begin
            if (reset && wr_en && (rf.wr == rf.pr2)) begin
                rf.rd2 = rf.wd;
            end else begin
                rf.rd2 = regs_q[rf.pr2];
            end
        end
    end
endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, bypass, zero register,
// asynchronous reset (including mid-write) and dual-port independence.
module tb_reg_file;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held low while a write is requested: nothing may commit.
        reset    = 1'b0;
        rf.write = 1'b1;
        rf.wr    = 5'd16;
        rf.wd    = 32'hFFFF_FFFF;
        rf.pr1   = 5'd0;
        rf.pr2   = 5'd16;
        #1;
        check("reset_rd1", rf.rd1, 32'h0);
        check("reset_rd2", rf.rd2, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_clk_rd1", rf.rd1, 32'h0);
        check("reset_clk_rd2", rf.rd2, 32'h0);

        // Release reset with the write still pending; bypass shows it first.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("wr16_bypass", rf.rd2, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rf.write = 1'b0;
        #1;
        check("wr16_stored", rf.rd2, 32'hFFFF_FFFF);
        check("wr16_rd1_zero", rf.rd1, 32'h0);

        // Write-through bypass on port 1.
        @(negedge clk);
        rf.write = 1'b1;
        rf.wr    = 5'd5;
        rf.wd    = 32'h1234_5678;
        rf.pr1   = 5'd5;
        #1;
        check("bypass_before_edge", rf.rd1, 32'h1234_5678);
        check("bypass_other_port", rf.rd2, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rf.write = 1'b0;
        rf.wd    = 32'h0;
        #1;
        check("bypass_after_edge", rf.rd1, 32'h1234_5678);

        // Register 0 stays zero, including through the bypass path.
        @(negedge clk);
        rf.write = 1'b1;
        rf.wr    = 5'd0;
        rf.wd    = 32'hDEAD_BEEF;
        rf.pr1   = 5'd0;
        rf.pr2   = 5'd0;
        #1;
        check("r0_before_rd1", rf.rd1, 32'h0);
        check("r0_before_rd2", rf.rd2, 32'h0);
        @(posedge clk);
        #1;
        rf.write = 1'b0;
        #1;
        check("r0_after_rd1", rf.rd1, 32'h0);
        check("r0_after_rd2", rf.rd2, 32'h0);

        // Asynchronous reset between edges clears stored data immediately.
        rf.pr1 = 5'd5;
        rf.pr2 = 5'd16;
        #1;
        check("pre_areset_r16", rf.rd2, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_now_r16", rf.rd2, 32'h0);
        check("areset_now_r5", rf.rd1, 32'h0);
        @(posedge clk);
        #1;
        check("areset_edge_r16", rf.rd2, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_release_r16", rf.rd2, 32'h0);
        check("areset_release_r5", rf.rd1, 32'h0);

        // Reset arriving mid-cycle cancels the pending write.
        @(negedge clk);
        rf.write = 1'b1;
        rf.wr    = 5'd9;
        rf.wd    = 32'hCAFE_0001;
        rf.pr1   = 5'd9;
        #1;
        check("midwr_bypass", rf.rd1, 32'hCAFE_0001);
        reset = 1'b0;
        #1;
        check("midwr_reset_now", rf.rd1, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rf.write = 1'b0;
        reset    = 1'b1;
        #1;
        check("midwr_lost", rf.rd1, 32'h0);

        // Dual-port independence.
        @(negedge clk);
        rf.write = 1'b1;
        rf.wr    = 5'd3;
        rf.wd    = 32'hA5A5_A5A5;
        @(negedge clk);
        rf.wr    = 5'd7;
        rf.wd    = 32'h5A5A_5A5A;
        rf.pr1   = 5'd3;
        rf.pr2   = 5'd7;
        #1;
        check("dual_r3_during_w7", rf.rd1, 32'hA5A5_A5A5);
        @(negedge clk);
        rf.write = 1'b0;
        #1;
        check("dual_rd1_r3", rf.rd1, 32'hA5A5_A5A5);
        check("dual_rd2_r7", rf.rd2, 32'h5A5A_5A5A);
        rf.pr1 = 5'd7;
        #1;
        check("same_idx_rd1", rf.rd1, 32'h5A5A_5A5A);
        check("same_idx_rd2", rf.rd2, 32'h5A5A_5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_reg_file
